// File: rtl/kbd_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code decoder.
package kbd_pkg;

  localparam logic [7:0] KBD_BREAK  = 8'hF0;
  localparam logic [7:0] KBD_EXT    = 8'hE0;
  localparam logic [7:0] KBD_LSHIFT = 8'h12;
  localparam logic [7:0] KBD_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/kbd_ascii_lut.sv
// Combinational PS/2 set-2 scan code to ASCII map; extended codes map to 0.
module kbd_ascii_lut (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic       is_letter;

  always_comb begin
    lower = 8'h00;
    case (code)
      8'h1C: lower = 8'h61;  8'h32: lower = 8'h62;  8'h21: lower = 8'h63;
      8'h23: lower = 8'h64;  8'h24: lower = 8'h65;  8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67;  8'h33: lower = 8'h68;  8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A;  8'h42: lower = 8'h6B;  8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D;  8'h31: lower = 8'h6E;  8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70;  8'h15: lower = 8'h71;  8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73;  8'h2C: lower = 8'h74;  8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76;  8'h1D: lower = 8'h77;  8'h22: lower = 8'h78;
      8'h35: lower = 8'h79;  8'h1A: lower = 8'h7A;
      8'h45: lower = 8'h30;  8'h16: lower = 8'h31;  8'h1E: lower = 8'h32;
      8'h26: lower = 8'h33;  8'h25: lower = 8'h34;  8'h2E: lower = 8'h35;
      8'h36: lower = 8'h36;  8'h3D: lower = 8'h37;  8'h3E: lower = 8'h38;
      8'h46: lower = 8'h39;
      8'h29: lower = 8'h20;
      8'h5A: lower = 8'h0D;
      default: lower = 8'h00;
    endcase
  end

  assign is_letter = (lower >= 8'h61) && (lower <= 8'h7A);

  always_comb begin
    ascii = lower;
    if (shift && is_letter)
      ascii = lower - 8'h20;
    if (ext)
      ascii = 8'h00;
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Pops PS/2 FIFO bytes and tracks the current held key, its ASCII and a press count.
// Optional build macro KBD_SHIFT_EN adds shift tracking for uppercase letters.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       scan_code,
  output logic             ext_key,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_flag
);

  state_t           state_reg, state_next;
  logic [7:0]       byte_reg, byte_next;
  logic             brk_reg, brk_next;
  logic             ext_reg, ext_next;
  logic             nd_reg, nd_next;
  logic             kv_reg, kv_next;
  logic [7:0]       code_reg, code_next;
  logic             extk_reg, extk_next;
  logic [7:0]       ascii_reg, ascii_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             shift_cur;
  logic [7:0]       lut_ascii;
  logic             held_match;

`ifdef KBD_SHIFT_EN
  logic shift_reg, shift_next;
  logic is_shift;
  assign is_shift  = !ext_reg && ((byte_reg == KBD_LSHIFT) || (byte_reg == KBD_RSHIFT));
  assign shift_cur = shift_reg;
`else
  assign shift_cur = 1'b0;
`endif

  kbd_ascii_lut u_lut (
    .code  (byte_reg),
    .ext   (ext_reg),
    .shift (shift_cur),
    .ascii (lut_ascii)
  );

  assign held_match = kv_reg && (byte_reg == code_reg) && (ext_reg == extk_reg);

  always_comb begin
    state_next = state_reg;
    byte_next  = byte_reg;
    brk_next   = brk_reg;
    ext_next   = ext_reg;
    nd_next    = nd_reg;
    kv_next    = kv_reg;
    code_next  = code_reg;
    extk_next  = extk_reg;
    ascii_next = ascii_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg | ps2_overflow;
`ifdef KBD_SHIFT_EN
    shift_next = shift_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (ps2_ready) begin
          byte_next  = ps2_data;
          nd_next    = 1'b0;
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        nd_next    = 1'b1;
        state_next = ST_GAP;
        if (byte_reg == KBD_BREAK) begin
          brk_next = 1'b1;
        end else if (byte_reg == KBD_EXT) begin
          ext_next = 1'b1;
`ifdef KBD_SHIFT_EN
        end else if (is_shift) begin
          shift_next = !brk_reg;
          brk_next   = 1'b0;
          ext_next   = 1'b0;
`endif
        end else if (brk_reg) begin
          // Breaks for anything but the held key are stale and dropped.
          if (held_match)
            kv_next = 1'b0;
          brk_next = 1'b0;
          ext_next = 1'b0;
        end else begin
          if (!held_match) begin
            kv_next    = 1'b1;
            code_next  = byte_reg;
            extk_next  = ext_reg;
            ascii_next = lut_ascii;
            cnt_next   = cnt_reg + 1'b1;
          end
          ext_next = 1'b0;
        end
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      byte_reg  <= 8'h00;
      brk_reg   <= 1'b0;
      ext_reg   <= 1'b0;
      nd_reg    <= 1'b1;
      kv_reg    <= 1'b0;
      code_reg  <= 8'h00;
      extk_reg  <= 1'b0;
      ascii_reg <= 8'h00;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
`ifdef KBD_SHIFT_EN
      shift_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      byte_reg  <= byte_next;
      brk_reg   <= brk_next;
      ext_reg   <= ext_next;
      nd_reg    <= nd_next;
      kv_reg    <= kv_next;
      code_reg  <= code_next;
      extk_reg  <= extk_next;
      ascii_reg <= ascii_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
`ifdef KBD_SHIFT_EN
      shift_reg <= shift_next;
`endif
    end
  end

  assign ps2_nextdata_n = nd_reg;
  assign key_valid      = kv_reg;
  assign scan_code      = code_reg;
  assign ext_key        = extk_reg;
  assign ascii          = ascii_reg;
  assign press_cnt      = cnt_reg;
  assign ovf_flag       = ovf_reg;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Bench for kbd_scan_decoder: FIFO model, reference key model and an expected-record scoreboard.
module tb_kbd_scan_decoder;

  typedef struct packed {
    logic       kv;
    logic       ext;
    logic [7:0] code;
    logic [7:0] asc;
    logic [7:0] cnt;
  } rec_t;

  localparam logic [7:0] LET_CODES [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
`ifdef KBD_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n;
  logic       key_valid;
  logic [7:0] scan_code;
  logic       ext_key;
  logic [7:0] ascii;
  logic [7:0] press_cnt;
  logic       ovf_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] fifo[$];
  rec_t       sb[$];
  int         low_cyc[$];
  bit         pending = 1'b0;
  rec_t       exp_pend;
  logic [7:0] pend_byte;

  // reference model state
  logic       m_kv, m_ext, m_brk, m_extk, m_shift;
  logic [7:0] m_code, m_asc, m_cnt;

  rec_t rec_out;
  assign rec_out = {key_valid, ext_key, scan_code, ascii, press_cnt};

  kbd_scan_decoder #(.CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_data       (ps2_data),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .key_valid      (key_valid),
    .scan_code      (scan_code),
    .ext_key        (ext_key),
    .ascii          (ascii),
    .press_cnt      (press_cnt),
    .ovf_flag       (ovf_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic e, input logic sh);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (LET_CODES[i] == c) return sh ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (DIG_CODES[i] == c) return 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic fifo_drive();
    ps2_ready = (fifo.size() != 0);
    ps2_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_kv = 0; m_ext = 0; m_brk = 0; m_extk = 0; m_shift = 0;
    m_code = 0; m_asc = 0; m_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rec_t r;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (SHIFT_EN && !m_ext && (b == 8'h12 || b == 8'h59)) begin
      m_shift = !m_brk; m_brk = 1'b0; m_ext = 1'b0;
    end else if (m_brk) begin
      if (m_kv && b == m_code && m_ext == m_extk) m_kv = 1'b0;
      m_brk = 1'b0; m_ext = 1'b0;
    end else begin
      if (!(m_kv && b == m_code && m_ext == m_extk)) begin
        m_kv = 1'b1; m_code = b; m_extk = m_ext;
        m_asc = ref_ascii(b, m_ext, m_shift);
        m_cnt = m_cnt + 8'd1;
      end
      m_ext = 1'b0;
    end
    r = {m_kv, m_extk, m_code, m_asc, m_cnt};
    sb.push_back(r);
    fifo.push_back(b);
    fifo_drive();
  endtask

  // FIFO pops and scoreboard comparisons happen at the falling edge.
  always @(negedge clk) begin
    if (pending) begin
      check("txn", rec_out, exp_pend);
      $display("txn byte %02h: kv=%0d ext=%0d code=%02h ascii=%02h cnt=%0d", pend_byte,
               key_valid, ext_key, scan_code, ascii, press_cnt);
      pending = 1'b0;
    end
    if (ps2_nextdata_n == 1'b0) begin
      low_cyc.push_back(cyc);
      check("pop_with_data", 32'(fifo.size() != 0 && sb.size() != 0), 32'd1);
      if (fifo.size() != 0 && sb.size() != 0) begin
        pend_byte = fifo.pop_front();
        exp_pend  = sb.pop_front();
        fifo_drive();
        if (!rst) pending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((fifo.size() != 0 || pending) && k < 5000) begin
      tick();
      k++;
    end
    check("drain", 32'(fifo.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    fifo.delete();
    sb.delete();
    fifo_drive();
  endtask

  initial begin
    int c0;
    int k;
    model_reset();
    // 1: reset values with the FIFO empty
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("rst_nd", 32'(ps2_nextdata_n), 32'd1);
      check("rst_rec", rec_out, 32'd0);
      tick();
    end
    check("rst_ovf", 32'(ovf_flag), 32'd0);

    // 2: make, typematic repeats, break
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C);
    push_byte(8'hF0); push_byte(8'h1C);
    drain();
    check("brk_kv", 32'(key_valid), 32'd0);
    check("brk_code", 32'(scan_code), 32'h1C);
    check("rpt_cnt", 32'(press_cnt), 32'd1);

    // 3: back-to-back cadence with ready held high
    low_cyc.delete();
    c0 = cyc;
    push_byte(8'h1B); push_byte(8'hF0); push_byte(8'h1B);
    drain();
    check("nd_lows", 32'(low_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < low_cyc.size(); i++)
      check("nd_cycle", 32'(low_cyc[i]), 32'(c0 + 1 + 3 * i));

    // 4: counter wrap, then reset during POP
    do_reset();
    for (int i = 0; i < 256; i++) begin
      push_byte(8'h45); push_byte(8'hF0); push_byte(8'h45);
    end
    drain();
    check("wrap_cnt", 32'(press_cnt), 32'd0);
    check("wrap_ascii", 32'(ascii), 32'h30);
    push_byte(8'h16);
    drain();
    push_byte(8'h1E);
    k = 0;
    while (ps2_nextdata_n != 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check("pop_seen", 32'(ps2_nextdata_n), 32'd0);
    rst = 1'b1;
    tick();
    check("popreset_rec", rec_out, 32'd0);
    check("popreset_nd", 32'(ps2_nextdata_n), 32'd1);
    rst = 1'b0;
    model_reset();
    sb.delete();
    fifo.delete();
    fifo_drive();
    repeat (4) tick();

    // 5: extended key make/break and sticky overflow
    ps2_overflow = 1'b1;
    tick();
    ps2_overflow = 1'b0;
    push_byte(8'hE0); push_byte(8'h75);
    drain();
    check("ext_kv", 32'(key_valid), 32'd1);
    check("ext_key", 32'(ext_key), 32'd1);
    push_byte(8'h75); push_byte(8'hF0); push_byte(8'h75);
    push_byte(8'hF0); push_byte(8'hE0); push_byte(8'h75);
    drain();
    check("ext_rel_kv", 32'(key_valid), 32'd0);
    check("ext_rel_code", 32'(scan_code), 32'h75);
    check("ovf_sticky", 32'(ovf_flag), 32'd1);
    do_reset();
    check("ovf_clear", 32'(ovf_flag), 32'd0);

    // 6: shift then letter
    push_byte(8'h12); push_byte(8'h1C);
    drain();
`ifdef KBD_SHIFT_EN
    check("shift_ascii", 32'(ascii), 32'h41);
    check("shift_cnt", 32'(press_cnt), 32'd1);
`else
    check("shift_ascii", 32'(ascii), 32'h61);
    check("shift_cnt", 32'(press_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
